// File: rtl/inst_decode_pipe_pkg.sv
// Shared RV32I decode constants: opcodes, funct codes, instruction IDs and immediate formats.
package inst_decode_pipe_pkg;

  localparam int InstIDDepth = 6;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
  localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_B    = 3'd0, F3_H   = 3'd1, F3_W   = 3'd2;
  localparam logic [2:0] F3_BU   = 3'd4, F3_HU  = 3'd5;

  typedef enum logic [InstIDDepth-1:0] {
    ID_ILLEGAL = 6'd0,
    ID_LUI  = 6'd1,  ID_AUIPC = 6'd2,  ID_JAL  = 6'd3,  ID_JALR = 6'd4,
    ID_BEQ  = 6'd5,  ID_BNE   = 6'd6,  ID_BLT  = 6'd7,  ID_BGE  = 6'd8,
    ID_BLTU = 6'd9,  ID_BGEU  = 6'd10,
    ID_LB   = 6'd11, ID_LH    = 6'd12, ID_LW   = 6'd13, ID_LBU  = 6'd14, ID_LHU = 6'd15,
    ID_SB   = 6'd16, ID_SH    = 6'd17, ID_SW   = 6'd18,
    ID_ADDI = 6'd19, ID_SLTI  = 6'd20, ID_SLTIU = 6'd21, ID_XORI = 6'd22,
    ID_ORI  = 6'd23, ID_ANDI  = 6'd24, ID_SLLI = 6'd25, ID_SRLI = 6'd26, ID_SRAI = 6'd27,
    ID_ADD  = 6'd28, ID_SUB   = 6'd29, ID_SLL  = 6'd30, ID_SLT  = 6'd31, ID_SLTU = 6'd32,
    ID_XOR  = 6'd33, ID_SRL   = 6'd34, ID_SRA  = 6'd35, ID_OR   = 6'd36, ID_AND  = 6'd37
  } inst_id_e;

  // FMT_SH is the shift-immediate form: I-type layout with a zero-extended shamt.
  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } imm_fmt_e;

endpackage

// File: rtl/inst_decode_pipe_if.sv
// Upstream (IF), downstream (EX) and redirect signals of the decode stage.
interface inst_decode_pipe_if #(
    parameter int XLEN = 32,
    parameter int ID_W = inst_decode_pipe_pkg::InstIDDepth
);
    logic            in_vld, in_rdy;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_vld, out_rdy;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic            out_rs1_vld, out_rs2_vld, out_rd_vld;
    logic [XLEN-1:0] out_imm, out_pc;
    logic [ID_W-1:0] out_instID;
    logic            out_illegal;
    logic            jmp_vld;
    logic [XLEN-1:0] jmp_addr;

    modport master (
        output in_vld, in_inst, in_pc, out_rdy,
        input  in_rdy, out_vld, out_rs1, out_rs2, out_rd, out_rs1_vld, out_rs2_vld,
               out_rd_vld, out_imm, out_pc, out_instID, out_illegal, jmp_vld, jmp_addr
    );

    modport slave (
        input  in_vld, in_inst, in_pc, out_rdy,
        output in_rdy, out_vld, out_rs1, out_rs2, out_rd, out_rs1_vld, out_rs2_vld,
               out_rd_vld, out_imm, out_pc, out_instID, out_illegal, jmp_vld, jmp_addr
    );
endinterface

// File: rtl/inst_decode_pipe_core.sv
// Pure combinational RV32I decode: register fields, operand-use flags, immediate, ID, illegal.
module inst_decode_core
    import inst_decode_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            rs1_vld,
    output logic            rs2_vld,
    output logic            rd_vld,
    output logic [XLEN-1:0] imm,
    output inst_id_e        inst_id,
    output logic            illegal
);
    logic [6:0] opcode, f7;
    logic [2:0] f3;
    imm_fmt_e   fmt;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        fmt     = FMT_NONE;
        inst_id = ID_ILLEGAL;
        case (opcode)
            OPC_LUI:   begin fmt = FMT_U; inst_id = ID_LUI;   end
            OPC_AUIPC: begin fmt = FMT_U; inst_id = ID_AUIPC; end
            OPC_JAL:   begin fmt = FMT_J; inst_id = ID_JAL;   end
            OPC_JALR:  begin fmt = FMT_I; inst_id = (f3 == 3'd0) ? ID_JALR : ID_ILLEGAL; end
            OPC_BRANCH: begin
                fmt = FMT_B;
                case (f3)
                    F3_BEQ:  inst_id = ID_BEQ;
                    F3_BNE:  inst_id = ID_BNE;
                    F3_BLT:  inst_id = ID_BLT;
                    F3_BGE:  inst_id = ID_BGE;
                    F3_BLTU: inst_id = ID_BLTU;
                    F3_BGEU: inst_id = ID_BGEU;
                    default: inst_id = ID_ILLEGAL;
                endcase
            end
            OPC_LOAD: begin
                fmt = FMT_I;
                case (f3)
                    F3_B:    inst_id = ID_LB;
                    F3_H:    inst_id = ID_LH;
                    F3_W:    inst_id = ID_LW;
                    F3_BU:   inst_id = ID_LBU;
                    F3_HU:   inst_id = ID_LHU;
                    default: inst_id = ID_ILLEGAL;
                endcase
            end
            OPC_STORE: begin
                fmt = FMT_S;
                case (f3)
                    F3_B:    inst_id = ID_SB;
                    F3_H:    inst_id = ID_SH;
                    F3_W:    inst_id = ID_SW;
                    default: inst_id = ID_ILLEGAL;
                endcase
            end
            OPC_OP_IMM: begin
                fmt = FMT_I;
                case (f3)
                    F3_ADD:  inst_id = ID_ADDI;
                    F3_SLT:  inst_id = ID_SLTI;
                    F3_SLTU: inst_id = ID_SLTIU;
                    F3_XOR:  inst_id = ID_XORI;
                    F3_OR:   inst_id = ID_ORI;
                    F3_AND:  inst_id = ID_ANDI;
                    F3_SLL: begin
                        fmt     = FMT_SH;
                        inst_id = (f7 == F7_BASE) ? ID_SLLI : ID_ILLEGAL;
                    end
                    F3_SR: begin
                        fmt     = FMT_SH;
                        inst_id = (f7 == F7_BASE) ? ID_SRLI :
                                  (f7 == F7_ALT)  ? ID_SRAI : ID_ILLEGAL;
                    end
                    default: inst_id = ID_ILLEGAL;
                endcase
            end
            OPC_OP: begin
                fmt = FMT_R;
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD:  inst_id = ID_ADD;
                        F3_SLL:  inst_id = ID_SLL;
                        F3_SLT:  inst_id = ID_SLT;
                        F3_SLTU: inst_id = ID_SLTU;
                        F3_XOR:  inst_id = ID_XOR;
                        F3_SR:   inst_id = ID_SRL;
                        F3_OR:   inst_id = ID_OR;
                        default: inst_id = ID_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    inst_id = ID_SUB;
                end else if (f7 == F7_ALT && f3 == F3_SR) begin
                    inst_id = ID_SRA;
                end
            end
            default: inst_id = ID_ILLEGAL;
        endcase
        // An unrecognised funct3/funct7 collapses everything to the illegal form.
        if (inst_id == ID_ILLEGAL) fmt = FMT_NONE;
    end

    always_comb begin
        case (fmt)
            FMT_I:   imm = XLEN'($signed(inst[31:20]));
            FMT_SH:  imm = XLEN'(inst[24:20]);
            FMT_S:   imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            FMT_B:   imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            FMT_U:   imm = XLEN'($signed({inst[31:12], 12'b0}));
            FMT_J:   imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            default: imm = '0;
        endcase
    end

    assign rs1_vld = fmt inside {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B};
    assign rs2_vld = fmt inside {FMT_R, FMT_S, FMT_B};
    assign rd_vld  = (fmt inside {FMT_R, FMT_I, FMT_SH, FMT_U, FMT_J}) && (rd != 5'd0);
    assign illegal = (fmt == FMT_NONE);
endmodule

// File: rtl/inst_decode_pipe.sv
// Decode stage: 1-cycle latency output register with optional skid entry and JAL redirect.
module inst_decode_pipe
    import inst_decode_pipe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ID_W    = InstIDDepth,
    parameter int SKID_EN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    inst_decode_pipe_if.slave   bus
);
    typedef struct packed {
        logic [4:0]      rs1, rs2, rd;
        logic            rs1_vld, rs2_vld, rd_vld;
        logic [XLEN-1:0] imm;
        logic [ID_W-1:0] inst_id;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } dec_t;

    logic [4:0]      c_rs1, c_rs2, c_rd;
    logic            c_rs1_vld, c_rs2_vld, c_rd_vld, c_illegal;
    logic [XLEN-1:0] c_imm;
    inst_id_e        c_id;
    dec_t            dec, out_q, skid_q;
    logic            out_vld_q, skid_vld_q, jmp_vld_q;
    logic [XLEN-1:0] jmp_addr_q;
    logic            in_rdy, accept, take_jal;

    inst_decode_core #(.XLEN(XLEN)) u_core (
        .inst    (bus.in_inst),
        .rs1     (c_rs1),
        .rs2     (c_rs2),
        .rd      (c_rd),
        .rs1_vld (c_rs1_vld),
        .rs2_vld (c_rs2_vld),
        .rd_vld  (c_rd_vld),
        .imm     (c_imm),
        .inst_id (c_id),
        .illegal (c_illegal)
    );

    assign dec = '{rs1: c_rs1, rs2: c_rs2, rd: c_rd, rs1_vld: c_rs1_vld, rs2_vld: c_rs2_vld,
                   rd_vld: c_rd_vld, imm: c_imm, inst_id: ID_W'(c_id), pc: bus.in_pc,
                   illegal: c_illegal};

    // With the skid entry, in_rdy depends only on state, breaking the out_rdy -> in_rdy path.
    assign in_rdy   = (SKID_EN != 0) ? !skid_vld_q : (!out_vld_q || bus.out_rdy);
    assign accept   = bus.in_vld && in_rdy;
    assign take_jal = accept && (c_id == ID_JAL);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking (<=) so every register here samples the pre-edge values.
        if (rst) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            jmp_vld_q  <= 1'b0;
            jmp_addr_q <= '0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            jmp_vld_q  <= 1'b0;
        end else begin
            jmp_vld_q <= take_jal;
            if (take_jal) jmp_addr_q <= bus.in_pc + c_imm;
            // A full skid implies out_vld, so its entry drains on the next output handshake.
            if (skid_vld_q) begin
                if (bus.out_rdy) begin
                    out_q      <= skid_q;
                    skid_vld_q <= 1'b0;
                end
            end else if (accept) begin
                if (!out_vld_q || bus.out_rdy) begin
                    out_q     <= dec;
                    out_vld_q <= 1'b1;
                end else begin
                    skid_q     <= dec;
                    skid_vld_q <= 1'b1;
                end
            end else if (out_vld_q && bus.out_rdy) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign bus.in_rdy      = in_rdy;
    assign bus.out_vld     = out_vld_q;
    assign bus.out_rs1     = out_q.rs1;
    assign bus.out_rs2     = out_q.rs2;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_rs1_vld = out_q.rs1_vld;
    assign bus.out_rs2_vld = out_q.rs2_vld;
    assign bus.out_rd_vld  = out_q.rd_vld;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_instID  = out_q.inst_id;
    assign bus.out_pc      = out_q.pc;
    assign bus.out_illegal = out_q.illegal;
    assign bus.jmp_vld     = jmp_vld_q;
    assign bus.jmp_addr    = jmp_addr_q;
endmodule
